// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = 16;

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  // Index of the final data byte of an image holding n_words words.
  function automatic logic [CNT_W-1:0] last_byte_idx(input logic [CNT_W-1:0] n_words);
    return (n_words * CNT_W'(BYTES_PER_WORD)) - CNT_W'(1);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a byte stream into big-endian 32-bit words; the finished word is
// registered and held until the next one completes.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        strobe,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] sr_q,    sr_d;
  logic [1:0]  lane_q,  lane_d;
  logic [31:0] word_q,  word_d;
  logic        valid_q, valid_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    sr_d    = sr_q;
    lane_d  = lane_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear) begin
      sr_d   = '0;
      lane_d = '0;
    end else if (strobe) begin
      if (lane_q == 2'(BYTES_PER_WORD - 1)) begin
        word_d  = {sr_q, byte_in};
        valid_d = 1'b1;
        sr_d    = '0;
        lane_d  = '0;
      end else begin
        sr_d   = {sr_q[15:0], byte_in};
        lane_d = lane_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (reset) begin
      sr_q    <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word       = word_q;
  assign word_valid = valid_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a counted, checksummed byte image from the UART and
// writes it to instruction memory, holding the CPU in reset until it is good.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);

  state_t             state_q,    state_d;
  logic [CNT_W-1:0]   count_q,    count_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [7:0]         csum_q,     csum_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;

  logic [CNT_W-1:0]   n_words;
  logic               asm_strobe;
  logic               asm_clear;
  logic [31:0]        asm_word;
  logic               asm_valid;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    csum_d     = csum_q;
    mem_addr_d = mem_addr_q;
    n_words    = count_q;
    asm_strobe = 1'b0;
    unique case (state_q)
      CNT_HI: begin
        if (rx_done) begin
          count_d = {rx_data, 8'h00};
          state_d = CNT_LO;
        end
      end
      CNT_LO: begin
        if (rx_done) begin
          n_words = {count_q[15:8], rx_data};
          count_d = n_words;
          if (n_words == '0)
            state_d = CHECK;
          else if (int'(n_words) > MAX_WORDS)
            state_d = ERROR;
          else
            state_d = DATA;
        end
      end
      DATA: begin
        asm_strobe = rx_done;
        if (rx_done) begin
          csum_d     = csum_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          // The write lands a cycle later; latch its address now so it lines up.
          if (byte_cnt_q[1:0] == 2'b11) begin
            mem_addr_d = word_cnt_q[ADDR_W-1:0];
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
          if (byte_cnt_q == last_byte_idx(count_q))
            state_d = CHECK;
        end
      end
      CHECK: begin
        if (rx_done)
          state_d = (rx_data == csum_q) ? DONE : ERROR;
      end
      DONE, ERROR: ;
      default: state_d = CNT_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CNT_HI;
      count_q    <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      csum_q     <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      csum_q     <= csum_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign asm_clear = (state_q != DATA);

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (rx_data),
    .strobe     (asm_strobe),
    .clear      (asm_clear),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  assign mem_we     = asm_valid;
  assign mem_wdata  = asm_word;
  assign mem_addr   = mem_addr_q;
  assign load_done  = (state_q == DONE);
  assign load_error = (state_q == ERROR);
  assign cpu_reset  = (state_q != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes go into a scoreboard queue
// that a negedge monitor drains; status flags are checked after each image.
module tb_imem_loader;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef logic [7:0] byte_q_t [$];

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;

  int  n_checks = 0;
  int  n_pass   = 0;
  wr_t sb [$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every write the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%08h, none expected", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", mem_wdata, e.data);
      end
    end
  end

  task automatic expect_wr(input logic [9:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic check_reset_state();
    check("rst_mem_we",     32'(mem_we),     32'd0);
    check("rst_mem_addr",   32'(mem_addr),   32'd0);
    check("rst_mem_wdata",  mem_wdata,       32'd0);
    check("rst_cpu_reset",  32'(cpu_reset),  32'd1);
    check("rst_load_done",  32'(load_done),  32'd0);
    check("rst_load_error", 32'(load_error), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    rx_done = 1'b0;
    @(negedge clk);
    check_reset_state();
    reset = 1'b0;
  endtask

  // Gapped: one idle cycle between strobes. Back-to-back: strobe every cycle.
  // Both return on the negedge right after the last byte was clocked in.
  task automatic send_stream(input byte_q_t bs, input bit b2b);
    foreach (bs[i]) begin
      @(negedge clk);
      if (!b2b && i != 0) begin
        rx_done = 1'b0;
        @(negedge clk);
      end
      rx_data = bs[i];
      rx_done = 1'b1;
    end
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    check(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_status(input string name, input logic done, input logic err, input logic cpu_rst);
    check({name, "_done"},      32'(load_done),  32'(done));
    check({name, "_error"},     32'(load_error), 32'(err));
    check({name, "_cpu_reset"}, 32'(cpu_reset),  32'(cpu_rst));
  endtask

  initial begin
    reset   = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_state();
    reset = 1'b0;

    // Two-word image. The eight data bytes XOR to 0x00, so 0x00 is the good
    // checksum here and 0x88 the bad one.
    expect_wr(10'd0, 32'h1234_5678);
    expect_wr(10'd1, 32'h9ABC_DEF0);
    send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78}, 1'b0);
    check("we_latency", 32'(mem_we), 32'd1);
    @(negedge clk);
    check("we_one_cycle", 32'(mem_we),    32'd0);
    check("addr_hold0",   32'(mem_addr),  32'd0);
    check("wdata_hold0",  mem_wdata,      32'h1234_5678);
    send_stream('{8'h9A, 8'hBC, 8'hDE, 8'hF0}, 1'b0);
    @(negedge clk);
    check_status("pre_csum", 1'b0, 1'b0, 1'b1);
    send_stream('{8'h00}, 1'b0);
    check_status("good2", 1'b1, 1'b0, 1'b0);
    check("addr_hold1",  32'(mem_addr), 32'd1);
    check("wdata_hold1", mem_wdata,     32'h9ABC_DEF0);
    drain("good2_writes");

    // Bad checksum: both writes still happen.
    do_reset();
    expect_wr(10'd0, 32'h1234_5678);
    expect_wr(10'd1, 32'h9ABC_DEF0);
    send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                  8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h88}, 1'b0);
    check_status("badcsum", 1'b0, 1'b1, 1'b1);
    drain("badcsum_writes");

    // Zero-length image.
    do_reset();
    send_stream('{8'h00, 8'h00, 8'h00}, 1'b0);
    check_status("zero", 1'b1, 1'b0, 1'b0);
    drain("zero_writes");

    // Count exactly MAX_WORDS is accepted.
    do_reset();
    send_stream('{8'h04, 8'h00}, 1'b0);
    check_status("max_cnt", 1'b0, 1'b0, 1'b1);

    // Count MAX_WORDS+1 errors immediately and ignores later bytes.
    do_reset();
    send_stream('{8'h04, 8'h01}, 1'b0);
    check_status("oversize", 1'b0, 1'b1, 1'b1);
    send_stream('{8'h12, 8'h34, 8'h56, 8'h78, 8'h00}, 1'b1);
    check_status("oversize_sticky", 1'b0, 1'b1, 1'b1);
    drain("oversize_writes");

    // Reset part-way through word 1, then a clean one-word image.
    do_reset();
    expect_wr(10'd0, 32'h1234_5678);
    send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC}, 1'b0);
    do_reset();
    expect_wr(10'd0, 32'hAABB_CCDD);
    send_stream('{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00}, 1'b0);
    check_status("reload", 1'b1, 1'b0, 1'b0);
    drain("reload_writes");

    // Back-to-back strobes, then a stray byte after DONE.
    do_reset();
    expect_wr(10'd0, 32'hDEAD_BEEF);
    send_stream('{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22}, 1'b1);
    check_status("b2b", 1'b1, 1'b0, 1'b0);
    send_stream('{8'h55}, 1'b0);
    check_status("after_done", 1'b1, 1'b0, 1'b0);
    check("after_done_wdata", mem_wdata, 32'hDEAD_BEEF);
    drain("b2b_writes");

    // A strobe coincident with reset is dropped; 0x05 taken as count[15:8]
    // would make the following stream oversize.
    @(negedge clk);
    reset   = 1'b1;
    rx_data = 8'h05;
    rx_done = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    rx_done = 1'b0;
    send_stream('{8'h00, 8'h00, 8'h00}, 1'b0);
    check_status("rst_strobe", 1'b1, 1'b0, 1'b0);
    drain("rst_strobe_writes");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
